multicycle_control_fsm: RTL and testbench

//  Sequencer for the multicycle MIPS datapath; decodes the IR opcode and steps the shared ALU, memory, IR, PC and register file.

---
 rtl/multicycle_control_fsm.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multicycle MIPS control sequencer (LW/SW/BEQ/J/R/ADDI/SLTI)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int NBITS_OP  = 6,
    parameter int NBITS_ST  = 4,
    parameter int NBITS_CNT = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_Enable,
    input  logic [NBITS_OP-1:0]  i_Opcode,
    input  logic                 i_MemReady,
    output logic                 o_PCWrite,
    output logic                 o_PCWriteCond,
    output logic [1:0]           o_PCSource,
    output logic                 o_IorD,
    output logic                 o_IRWrite,
    output logic                 o_MemRead,
    output logic                 o_MemWrite,
    output logic                 o_MemToReg,
    output logic                 o_RegDst,
    output logic                 o_RegWrite,
    output logic                 o_ALUSrcA,
    output logic [1:0]           o_ALUSrcB,
    output logic [1:0]           o_ALUOp,
    output logic [NBITS_ST-1:0]  o_State,
    output logic                 o_InstrDone,
    output logic                 o_Halt,
    output logic [NBITS_CNT-1:0] o_InstrCount
);

    localparam logic [NBITS_OP-1:0]  c_OP_RTYPE = 6'b000000;
    localparam logic [NBITS_OP-1:0]  c_OP_LW    = 6'b100011;
    localparam logic [NBITS_OP-1:0]  c_OP_SW    = 6'b101011;
    localparam logic [NBITS_OP-1:0]  c_OP_BEQ   = 6'b000100;
    localparam logic [NBITS_OP-1:0]  c_OP_J     = 6'b000010;
    localparam logic [NBITS_OP-1:0]  c_OP_ADDI  = 6'b001000;
    localparam logic [NBITS_OP-1:0]  c_OP_SLTI  = 6'b001010;
    localparam logic [NBITS_CNT-1:0] c_CNT_ONE  = {{(NBITS_CNT-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IMMEX  = 4'd11,
        S_IMMWB  = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_done;
    logic [NBITS_CNT-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_done)
                r_count <= r_count + c_CNT_ONE;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_done        = 1'b0;
        o_PCWrite     = 1'b0;
        o_PCWriteCond = 1'b0;
        o_PCSource    = 2'b00;
        o_IorD        = 1'b0;
        o_IRWrite     = 1'b0;
        o_MemRead     = 1'b0;
        o_MemWrite    = 1'b0;
        o_MemToReg    = 1'b0;
        o_RegDst      = 1'b0;
        o_RegWrite    = 1'b0;
        o_ALUSrcA     = 1'b0;
        o_ALUSrcB     = 2'b00;
        o_ALUOp       = 2'b00;
        o_Halt        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Enable)
                    w_state_next = S_FETCH;
            end
            S_FETCH: begin
                o_MemRead = 1'b1;
                o_ALUSrcB = 2'b01;
                if (i_MemReady) begin
                    o_IRWrite    = 1'b1;
                    o_PCWrite    = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                o_ALUSrcB = 2'b11;
                case (i_Opcode)
                    c_OP_LW, c_OP_SW:     w_state_next = S_MEMADR;
                    c_OP_RTYPE:           w_state_next = S_EXEC;
                    c_OP_BEQ:             w_state_next = S_BRANCH;
                    c_OP_J:               w_state_next = S_JUMP;
                    c_OP_ADDI, c_OP_SLTI: w_state_next = S_IMMEX;
                    default:              w_state_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                o_ALUSrcA    = 1'b1;
                o_ALUSrcB    = 2'b10;
                w_state_next = (i_Opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_MemRead = 1'b1;
                o_IorD    = 1'b1;
                if (i_MemReady)
                    w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_RegWrite = 1'b1;
                o_MemToReg = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWR: begin
                o_MemWrite = 1'b1;
                o_IorD     = 1'b1;
                w_done     = i_MemReady;
            end
            S_EXEC: begin
                o_ALUSrcA    = 1'b1;
                o_ALUOp      = 2'b10;
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                o_RegWrite = 1'b1;
                o_RegDst   = 1'b1;
                w_done     = 1'b1;
            end
            S_BRANCH: begin
                o_ALUSrcA     = 1'b1;
                o_ALUOp       = 2'b01;
                o_PCWriteCond = 1'b1;
                o_PCSource    = 2'b01;
                w_done        = 1'b1;
            end
            S_JUMP: begin
                o_PCWrite  = 1'b1;
                o_PCSource = 2'b10;
                w_done     = 1'b1;
            end
            S_IMMEX: begin
                o_ALUSrcA    = 1'b1;
                o_ALUSrcB    = 2'b10;
                o_ALUOp      = (i_Opcode == c_OP_SLTI) ? 2'b11 : 2'b00;
                w_state_next = S_IMMWB;
            end
            S_IMMWB: begin
                o_RegWrite = 1'b1;
                w_done     = 1'b1;
            end
            S_HALT: begin
                o_Halt = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Every retiring state shares the same Enable-driven continuation
        if (w_done)
            w_state_next = i_Enable ? S_FETCH : S_IDLE;
    end

    assign o_InstrDone  = w_done;
    assign o_State      = NBITS_ST'(r_state);
    assign o_InstrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Directed self-checking bench for multicycle_control_fsm
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [5:0]  op  = 6'b0;
    logic        rdy = 1'b0;

    logic        pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, srca, done, halt;
    logic [1:0]  pcsrc, srcb, aluop;
    logic [3:0]  st;
    logic [31:0] cnt;

    logic        b_pcw, b_pcwc, b_iord, b_irw, b_mrd, b_mwr, b_m2r, b_rdst, b_rw, b_srca, b_done, b_halt;
    logic [1:0]  b_pcsrc, b_srcb, b_aluop;
    logic [3:0]  b_st;
    logic [1:0]  b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Opcode(op), .i_MemReady(rdy),
        .o_PCWrite(pcw), .o_PCWriteCond(pcwc), .o_PCSource(pcsrc), .o_IorD(iord),
        .o_IRWrite(irw), .o_MemRead(mrd), .o_MemWrite(mwr), .o_MemToReg(m2r),
        .o_RegDst(rdst), .o_RegWrite(rw), .o_ALUSrcA(srca), .o_ALUSrcB(srcb),
        .o_ALUOp(aluop), .o_State(st), .o_InstrDone(done), .o_Halt(halt),
        .o_InstrCount(cnt)
    );

    // Narrow counter copy so the wrap from all-ones is reachable in a few instructions
    multicycle_control_fsm #(.NBITS_CNT(2)) dut_w (
        .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Opcode(op), .i_MemReady(rdy),
        .o_PCWrite(b_pcw), .o_PCWriteCond(b_pcwc), .o_PCSource(b_pcsrc), .o_IorD(b_iord),
        .o_IRWrite(b_irw), .o_MemRead(b_mrd), .o_MemWrite(b_mwr), .o_MemToReg(b_m2r),
        .o_RegDst(b_rdst), .o_RegWrite(b_rw), .o_ALUSrcA(b_srca), .o_ALUSrcB(b_srcb),
        .o_ALUOp(b_aluop), .o_State(b_st), .o_InstrDone(b_done), .o_Halt(b_halt),
        .o_InstrCount(b_cnt)
    );

    wire [17:0] w_outs = {pcw, pcwc, pcsrc, iord, irw, mrd, mwr, m2r, rdst, rw,
                          srca, srcb, aluop, done, halt};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (st !== 4'd0 || w_outs !== 18'd0 || cnt !== 32'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d state=%0d outs=%h cnt=%0d required state=0 outs=0 cnt=0", i, st, w_outs, cnt);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (st !== 4'd1 || mrd !== 1'b1 || srcb !== 2'b01) begin
            failures++;
            $display("FAIL enable_fetch state=%0d memread=%b srcb=%b required 1/1/01", st, mrd, srcb);
        end
    endtask

    task automatic test_sequence();
        logic [5:0] ops[7]  = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000010, 6'b001000, 6'b001010};
        int         lat[7]  = '{4, 5, 4, 3, 3, 4, 4};
        int         cyc;
        rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            op  = ops[k];
            cyc = 1;
            while (!done && cyc < 20) begin
                if (st == 4'd11) begin
                    checks++;
                    if (aluop !== ((op == 6'b001010) ? 2'b11 : 2'b00)) begin
                        failures++;
                        $display("FAIL immex_aluop op=%b got=%b", op, aluop);
                    end
                end
                tick();
                cyc++;
            end
            checks++;
            if (cyc !== lat[k]) begin
                failures++;
                $display("FAIL latency op=%b got=%0d required=%0d", ops[k], cyc, lat[k]);
            end
            tick();
        end
        checks++;
        if (cnt !== 32'd7 || st !== 4'd1) begin
            failures++;
            $display("FAIL count_seq cnt=%0d state=%0d required cnt=7 state=1", cnt, st);
        end
    endtask

    task automatic test_fetch_wait();
        op  = 6'b000000;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (st !== 4'd1 || irw !== 1'b0 || pcw !== 1'b0 || mrd !== 1'b1) begin
                failures++;
                $display("FAIL fetch_wait cyc=%0d state=%0d irw=%b pcw=%b mrd=%b required 1/0/0/1", i, st, irw, pcw, mrd);
            end
            tick();
        end
        rdy = 1'b1;
        #1;
        checks++;
        if (irw !== 1'b1 || pcw !== 1'b1) begin
            failures++;
            $display("FAIL fetch_ready irw=%b pcw=%b required 1/1", irw, pcw);
        end
        tick();
        checks++;
        if (st !== 4'd2 || irw !== 1'b0 || pcw !== 1'b0 || srcb !== 2'b11) begin
            failures++;
            $display("FAIL decode state=%0d irw=%b pcw=%b srcb=%b required 2/0/0/11", st, irw, pcw, srcb);
        end
    endtask

    task automatic test_enable_drop();
        tick();
        checks++;
        if (st !== 4'd7 || aluop !== 2'b10 || srca !== 1'b1) begin
            failures++;
            $display("FAIL exec state=%0d aluop=%b srca=%b required 7/10/1", st, aluop, srca);
        end
        en = 1'b0;
        tick();
        checks++;
        if (st !== 4'd8 || done !== 1'b1 || rw !== 1'b1 || rdst !== 1'b1) begin
            failures++;
            $display("FAIL aluwb state=%0d done=%b rw=%b rdst=%b required 8/1/1/1", st, done, rw, rdst);
        end
        tick();
        checks++;
        if (st !== 4'd0 || cnt !== 32'd8 || w_outs !== 18'd0) begin
            failures++;
            $display("FAIL drop_idle state=%0d cnt=%0d outs=%h required 0/8/0", st, cnt, w_outs);
        end
    endtask

    task automatic test_halt();
        en = 1'b1; rdy = 1'b1; op = 6'b111111;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (st !== 4'd13 || halt !== 1'b1 || cnt !== 32'd8 || w_outs !== 18'd1) begin
                failures++;
                $display("FAIL halt cyc=%0d state=%0d halt=%b cnt=%0d outs=%h required 13/1/8/1", i, st, halt, cnt, w_outs);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (st !== 4'd0 || cnt !== 32'd0 || halt !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset state=%0d cnt=%0d halt=%b required 0/0/0", st, cnt, halt);
        end
    endtask

    task automatic test_reset_memrd();
        op = 6'b100011; rdy = 1'b1;
        tick(); tick(); tick(); tick();
        rdy = 1'b0;
        #1;
        checks++;
        if (st !== 4'd4 || mrd !== 1'b1 || iord !== 1'b1) begin
            failures++;
            $display("FAIL memrd state=%0d mrd=%b iord=%b required 4/1/1", st, mrd, iord);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (st !== 4'd0 || mrd !== 1'b0) begin
            failures++;
            $display("FAIL memrd_reset state=%0d mrd=%b required 0/0", st, mrd);
        end
    endtask

    task automatic test_wrap();
        op = 6'b000010; rdy = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (b_cnt !== 2'b11 || st !== 4'd1) begin
            failures++;
            $display("FAIL wrap_full cnt=%b state=%0d required 11/1", b_cnt, st);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (b_cnt !== 2'b00 || cnt !== 32'd4) begin
            failures++;
            $display("FAIL wrap_zero narrow=%b wide=%0d required 00/4", b_cnt, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_fetch_wait();
        test_enable_drop();
        test_halt();
        test_reset_memrd();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
